// File: rtl/mole_scheduler.sv
// Whack-a-mole game scheduler: one-hot mole placement, hit scoring and game timing.
// Ports: clk/rst_n, start pulse, btn[3:0] whack pulses -> mole[3:0], score[7:0],
//        time_left[5:0], busy (SHOW/GAP), game_over (DONE). All outputs registered.
module mole_scheduler #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int GAME_SECS = 30,
  parameter int MOLE_SECS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [5:0] time_left,
  output logic       busy,
  output logic       game_over
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    MOLE_MAX = 4'(MOLE_SECS - 1);
  localparam logic [5:0]    GAME_LEN = 6'(GAME_SECS);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic [3:0]      mtmr, mtmr_nx;
  logic [1:0]      prev, prev_nx;
  logic [7:0]      lfsr;
  logic [3:0]      mole_nx;
  logic [7:0]      score_nx;
  logic [5:0]      time_nx;

  logic            run, tick, final_tick, hit;
  logic [1:0]      idx, hole;
  logic [3:0]      hole_oh;

  assign run        = (state == SHOW) || (state == GAP);
  assign tick       = run && (presc == TICK_MAX);
  assign final_tick = tick && (time_left == 6'd1);
  // mole is zero outside SHOW, so any overlap is a hit; several matching bits still count once.
  assign hit        = (state == SHOW) && |(btn & mole);

  // Step to the neighbouring hole when the random pick repeats the last one.
  assign idx     = lfsr[1:0];
  assign hole    = (idx == prev) ? idx + 2'd1 : idx;
  assign hole_oh = 4'b0001 << hole;

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    mtmr_nx  = mtmr;
    prev_nx  = prev;
    mole_nx  = mole;
    score_nx = score;
    time_nx  = time_left;

    if (run) presc_nx = tick ? '0 : presc + 1'b1;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = SHOW;
          score_nx = 8'd0;
          time_nx  = GAME_LEN;
          mtmr_nx  = 4'd0;
          presc_nx = '0;
          mole_nx  = hole_oh;
          prev_nx  = hole;
        end
      end
      SHOW: begin
        if (hit && (score != 8'hFF)) score_nx = score + 8'd1;
        if (tick) time_nx = time_left - 6'd1;
        // End of game outranks both hit and miss; the hit above is still scored.
        if (final_tick) begin
          state_nx = DONE;
          mole_nx  = 4'd0;
        end else if (hit) begin
          state_nx = GAP;
          mole_nx  = 4'd0;
        end else if (tick) begin
          if (mtmr == MOLE_MAX) begin
            state_nx = GAP;
            mole_nx  = 4'd0;
          end else begin
            mtmr_nx = mtmr + 4'd1;
          end
        end
      end
      GAP: begin
        if (tick) time_nx = time_left - 6'd1;
        if (final_tick) begin
          state_nx = DONE;
          mole_nx  = 4'd0;
        end else if (tick) begin
          state_nx = SHOW;
          mole_nx  = hole_oh;
          prev_nx  = hole;
          mtmr_nx  = 4'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      mtmr      <= 4'd0;
      prev      <= 2'd0;
      lfsr      <= 8'hA5;
      mole      <= 4'd0;
      score     <= 8'd0;
      time_left <= 6'd0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      mtmr      <= mtmr_nx;
      prev      <= prev_nx;
      // x^8+x^6+x^5+x^4+1, free-running in every state.
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      mole      <= mole_nx;
      score     <= score_nx;
      time_left <= time_nx;
      busy      <= (state_nx == SHOW) || (state_nx == GAP);
      game_over <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with TICK_DIV=4, GAME_SECS=3, MOLE_SECS=2.
// Ports: drives clk/rst_n/start/btn, checks mole/score/time_left/busy/game_over.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] btn;
  logic [3:0] mole;
  logic [7:0] score;
  logic [5:0] time_left;
  logic       busy;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  // Reference hole picker: own LFSR plus the last hole the bench saw.
  logic [7:0] lfsr_m;
  logic [1:0] prev_m;
  logic [1:0] cand;
  logic [3:0] last_mole;
  logic [3:0] saved;

  mole_scheduler #(.TICK_DIV(4), .GAME_SECS(3), .MOLE_SECS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn),
    .mole(mole), .score(score), .time_left(time_left),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] pick(input logic [1:0] i, input logic [1:0] p);
    return (i == p) ? i + 2'd1 : i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m <= 8'hA5;
      cand   <= 2'd0;
    end else begin
      cand   <= pick(lfsr_m[1:0], prev_m);
      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles; sample at the falling edge and check every freshly shown mole.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      btn   = 4'd0;
      if (last_mole == 4'd0 && mole != 4'd0) begin
        chk("new_hole", {28'd0, mole}, 32'd1 << cand);
        prev_m = cand;
      end
      last_mole = mole;
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_mole"},  {28'd0, mole}, 0);
    chk({tag, "_score"}, {24'd0, score}, 0);
    chk({tag, "_time"},  {26'd0, time_left}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_over"},  {31'd0, game_over}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; btn = 4'd0;
    prev_m = 2'd0; last_mole = 4'd0; saved = 4'd0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", {31'd0, busy}, 0);

    // Game 1: start, hit, ignored start, wrong hole, hit on the final tick.
    start = 1'b1; step(1);                       // E1: SHOW
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_time", {26'd0, time_left}, 3);
    chk("start_score", {24'd0, score}, 0);
    chk("start_over", {31'd0, game_over}, 0);
    chk("start_onehot", {31'd0, $onehot(mole)}, 1);
    step(1);                                     // E2
    saved = mole;
    btn = mole; step(1);                         // E3: hit -> GAP
    chk("hit1_score", {24'd0, score}, 1);
    chk("hit1_mole", {28'd0, mole}, 0);
    chk("gap_busy", {31'd0, busy}, 1);
    step(2);                                     // E5: tick -> SHOW new hole
    chk("reshow_onehot", {31'd0, $onehot(mole)}, 1);
    chk("reshow_diff", {31'd0, mole == saved}, 0);
    chk("tick1_time", {26'd0, time_left}, 2);
    start = 1'b1; step(1);                       // E6: start ignored
    chk("ign_start_time", {26'd0, time_left}, 2);
    chk("ign_start_score", {24'd0, score}, 1);
    saved = mole;
    btn = ~mole; step(1);                        // E7: wrong holes only
    chk("wrong_score", {24'd0, score}, 1);
    chk("wrong_mole", {28'd0, mole}, {28'd0, saved});
    step(5);                                     // E12: one tick before end
    chk("pre_end_time", {26'd0, time_left}, 1);
    chk("pre_end_busy", {31'd0, busy}, 1);
    chk("pre_end_mole", {28'd0, mole}, {28'd0, saved});
    btn = 4'hF; step(1);                         // E13: hit + final tick
    chk("final_score", {24'd0, score}, 2);
    chk("final_over", {31'd0, game_over}, 1);
    chk("final_time", {26'd0, time_left}, 0);
    chk("final_mole", {28'd0, mole}, 0);
    chk("final_busy", {31'd0, busy}, 0);
    btn = 4'hF; step(3);
    chk("done_hold_score", {24'd0, score}, 2);
    chk("done_hold_over", {31'd0, game_over}, 1);

    // Game 2: restart from DONE, no presses, two misses' worth of ticks.
    start = 1'b1; step(1);                       // F1
    chk("restart_score", {24'd0, score}, 0);
    chk("restart_time", {26'd0, time_left}, 3);
    chk("restart_over", {31'd0, game_over}, 0);
    step(7);                                     // F8
    chk("show_f8", {31'd0, mole != 4'd0}, 1);
    step(1);                                     // F9: miss
    chk("miss_mole", {28'd0, mole}, 0);
    chk("miss_score", {24'd0, score}, 0);
    chk("miss_time", {26'd0, time_left}, 1);
    step(3);                                     // F12
    chk("f12_busy", {31'd0, busy}, 1);
    step(1);                                     // F13: DONE
    chk("timeout_over", {31'd0, game_over}, 1);
    chk("timeout_time", {26'd0, time_left}, 0);
    chk("timeout_busy", {31'd0, busy}, 0);

    // Game 3: score 2, then reset in SHOW.
    start = 1'b1; step(1);                       // G1
    btn = mole; step(1);                         // G2
    step(3);                                     // G5: new mole
    btn = mole; step(1);                         // G6
    chk("g3_score", {24'd0, score}, 2);
    step(3);                                     // G9: SHOW again
    chk("g3_show", {31'd0, mole != 4'd0}, 1);
    #2 rst_n = 1'b0;
    #1;
    prev_m = 2'd0;
    chk_cleared("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    last_mole = mole;
    step(6);
    chk_cleared("post_rst");
    start = 1'b1; step(1);
    chk("post_rst_start_busy", {31'd0, busy}, 1);
    chk("post_rst_start_time", {26'd0, time_left}, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
